// File: rtl/spongent_scheduler_pkg.sv
// spongent_scheduler_pkg: shared FSM state type and default sizing for the SPONGENT scheduler
// Contents: state_e (IDLE/LAUNCH/RUN/RESP), DEF_DATA_WIDTH, DEF_N, DEF_TIMEOUT_CYCLES
package spongent_scheduler_pkg;
    localparam int DEF_DATA_WIDTH     = 64;
    localparam int DEF_N              = 88;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_RESP} state_e;
endpackage

// File: rtl/spongent_rr_arb2.sv
// spongent_rr_arb2: two-way round-robin arbiter with one-hot grant
// Ports: valid_i[1:0] requests, last_i requester served last, en_i grant enable, grant_o[1:0] one-hot grant
module spongent_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);
    // On contention the requester not served last wins.
    always_comb grant_o = !en_i ? 2'b00 : &valid_i ? (last_i ? 2'b01 : 2'b10) : valid_i;
endmodule

// File: rtl/spongent_scheduler.sv
// spongent_scheduler: arbitrates two requesters onto one shared SPONGENT hash core and returns tagged digests
// Ports: clk/rst_n (async active-low); req{0,1}_valid/msg/ready request side;
//        rsp_valid/ready/id/hash/err response side; core_rst/core_msg/core_hash/core_end core side; busy (not IDLE).
// Option: SPONGENT_SCHEDULER_TIMEOUT_EN adds a RUN watchdog of TIMEOUT_CYCLES that ends the job with rsp_err=1.
module spongent_scheduler
    import spongent_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int N              = DEF_N,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_msg,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_msg,
    output logic                  req1_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [N-1:0]          rsp_hash,
    output logic                  rsp_err,
    output logic                  core_rst,
    output logic [DATA_WIDTH-1:0] core_msg,
    input  logic [N-1:0]          core_hash,
    input  logic                  core_end,
    output logic                  busy
);
    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic                  id_q, id_d;
    logic [DATA_WIDTH-1:0] msg_q, msg_d;
    logic [N-1:0]          hash_q, hash_d;
    logic [1:0]            grant;
    logic                  expire;
    // rst_n gates the enable so no ready can leak out while reset is held.
    spongent_rr_arb2 u_arb (
        .valid_i ({req1_valid, req0_valid}),
        .last_i  (last_q),
        .en_i    (state_q == S_IDLE && rst_n),
        .grant_o (grant)
    );
`ifdef SPONGENT_SCHEDULER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    // cnt_q holds the number of RUN cycles already completed; it restarts from 0 on every RUN entry.
    assign cnt_d  = state_q == S_RUN ? cnt_q + 1'b1 : '0;
    assign expire = state_q == S_RUN && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    // core_end beats a simultaneous expiry, so the error is only raised when the core stayed silent.
    assign err_d  = state_q == S_RUN ? expire && !core_end : err_q;
    assign rsp_err = err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign expire  = 1'b0;
    assign rsp_err = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        msg_d   = msg_q;
        hash_d  = hash_q;
        case (state_q)
            S_IDLE: if (|grant) begin
                state_d = S_LAUNCH;
                id_d    = grant[1];
                msg_d   = grant[1] ? req1_msg : req0_msg;
            end
            S_LAUNCH: state_d = S_RUN;
            S_RUN: if (core_end) begin
                state_d = S_RESP;
                hash_d  = core_hash;
            end else if (expire) begin
                state_d = S_RESP;
                hash_d  = '0;
            end
            S_RESP: if (rsp_ready) begin
                state_d = S_IDLE;
                last_d  = id_q;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            msg_q   <= '0;
            hash_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            msg_q   <= msg_d;
            hash_q  <= hash_d;
        end
    end
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp_valid  = state_q == S_RESP;
    assign rsp_id     = id_q;
    assign rsp_hash   = hash_q;
    assign core_msg   = msg_q;
    assign core_rst   = state_q == S_IDLE || state_q == S_LAUNCH;
    assign busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_spongent_scheduler.sv
// tb_spongent_scheduler: scoreboard bench for spongent_scheduler with a fixed-latency hash core model
module tb_spongent_scheduler;
    localparam int DW = 64;
    localparam int NW = 88;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid, req1_valid, req0_ready, req1_ready;
    logic [DW-1:0] req0_msg, req1_msg, core_msg;
    logic rsp_valid, rsp_ready, rsp_id, rsp_err, core_rst, core_end, busy;
    logic [NW-1:0] rsp_hash, core_hash;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int run_cnt = 0;
    int end_at = 49;
    int rdy0_cnt = 0;
    int rdy1_cnt = 0;
    logic prev_valid = 1'b0;
    typedef struct {
        logic          id;
        logic [NW-1:0] hash;
        logic          err;
        int            acc;
        int            lat;
    } exp_t;
    exp_t sb[$];
    spongent_scheduler #(.DATA_WIDTH(DW), .N(NW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_msg(req0_msg), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_msg(req1_msg), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_hash(rsp_hash), .rsp_err(rsp_err),
        .core_rst(core_rst), .core_msg(core_msg), .core_hash(core_hash), .core_end(core_end), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [NW-1:0] model_hash(input logic [DW-1:0] m);
        return {24'hC0FFEE, m ^ 64'hDEADBEEF_CAFEF00D};
    endfunction
    // Core model: core_end in the (end_at+1)-th cycle with core_rst low; end_at < 0 never ends.
    always @(posedge clk) run_cnt <= core_rst ? 0 : run_cnt + 1;
    assign core_end  = !core_rst && run_cnt == end_at;
    assign core_hash = model_hash(core_msg);
    task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            rdy0_cnt += int'(req0_ready);
            rdy1_cnt += int'(req1_ready);
            if (req0_ready || req1_ready) chk("ready_idle_onehot", {busy, req0_ready & req1_ready}, 2'b00);
            if (rsp_valid && !prev_valid) begin
                chk("rsp_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    chk("rsp_id", rsp_id, sb[0].id);
                    chk("rsp_hash", rsp_hash, sb[0].hash);
                    chk("rsp_err", rsp_err, sb[0].err);
                    if (sb[0].lat > 0) chk("latency", cyc - sb[0].acc, sb[0].lat);
                end
            end
            if (rsp_valid && rsp_ready && sb.size() != 0) void'(sb.pop_front());
        end
        prev_valid = rsp_valid && rst_n;
    end
    task automatic wait_ready(input int bound, output logic ok, output logic who);
        ok = 1'b0;
        who = 1'b0;
        for (int i = 0; i < bound; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                ok = 1'b1;
                who = req1_ready;
                return;
            end
            @(negedge clk);
        end
    endtask
    task automatic wait_drain(input string name, input int bound);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            #3;
            ok = sb.size() == 0 && !busy;
        end
        chk(name, ok, 1'b1);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic job(input string name, input logic exp_id, input logic [DW-1:0] msg,
                       input logic [NW-1:0] exp_hash, input logic exp_err, input int lat);
        logic ok, who;
        wait_ready(100, ok, who);
        chk(name, {ok, who}, {1'b1, exp_id});
        sb.push_back('{exp_id, exp_hash, exp_err, cyc, lat});
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("launch_core_msg", core_msg, msg);
    endtask
    initial begin
        logic ok, who;
        int r0, r1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_msg = '0;
        req1_msg = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("reset_ctrl", {core_rst, busy, rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready}, 7'b1000000);
        chk("reset_hash", rsp_hash, '0);
        chk("reset_core_msg", core_msg, '0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        // single request
        req0_msg = 64'h0123456789ABCDEF;
        req0_valid = 1'b1;
        job("t1_grant", 1'b0, 64'h0123456789ABCDEF, model_hash(64'h0123456789ABCDEF), 1'b0, 52);
        chk("t1_launch", {core_rst, busy}, 2'b11);
        @(negedge clk);
        chk("t1_run_core_rst", {core_rst, busy}, 2'b01);
        wait_drain("t1_drain", 200);
        // contention
        do_reset();
        r0 = rdy0_cnt;
        r1 = rdy1_cnt;
        req0_msg = 64'h1111_1111_1111_1111;
        req1_msg = 64'h2222_2222_2222_2222;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ready(200, ok, who);
            chk("t2_grant_order", {ok, who}, {1'b1, k[0]});
            sb.push_back('{k[0], model_hash(k[0] ? 64'h2222_2222_2222_2222 : 64'h1111_1111_1111_1111), 1'b0, cyc, 52});
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain("t2_drain", 300);
        chk("t2_ready0_pulses", rdy0_cnt - r0, 2);
        chk("t2_ready1_pulses", rdy1_cnt - r1, 2);
        // backpressure
        rsp_ready = 1'b0;
        req1_msg = 64'h3333_3333_3333_3333;
        req1_valid = 1'b1;
        job("t3_grant", 1'b1, 64'h3333_3333_3333_3333, model_hash(64'h3333_3333_3333_3333), 1'b0, 52);
        req0_msg = 64'h4444_4444_4444_4444;
        req0_valid = 1'b1;
        r0 = rdy0_cnt;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = rsp_valid;
        end
        chk("t3_rsp_valid", ok, 1'b1);
        for (int i = 0; i < 20; i++) begin
            chk("t3_hold", {rsp_valid, busy, rsp_id, rsp_err, rsp_hash}, {4'b1110, model_hash(64'h3333_3333_3333_3333)});
            @(negedge clk);
            #1;
        end
        chk("t3_no_ready", rdy0_cnt - r0, 0);
        rsp_ready = 1'b1;
        job("t3_next_grant", 1'b0, 64'h4444_4444_4444_4444, model_hash(64'h4444_4444_4444_4444), 1'b0, 52);
        wait_drain("t3_drain", 200);
        // reset mid-RUN
        req1_msg = 64'h5555_5555_5555_5555;
        req1_valid = 1'b1;
        wait_ready(20, ok, who);
        chk("t4_grant", {ok, who}, 2'b11);
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_in_run", {busy, core_rst}, 2'b10);
        req0_msg = 64'h6666_6666_6666_6666;
        req0_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t4_reset_ctrl", {core_rst, busy, rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready}, 7'b1000000);
        chk("t4_reset_hash", rsp_hash, '0);
        chk("t4_reset_core_msg", core_msg, '0);
        @(negedge clk);
        rst_n = 1'b1;
        job("t4_after_reset", 1'b0, 64'h6666_6666_6666_6666, model_hash(64'h6666_6666_6666_6666), 1'b0, 52);
        wait_drain("t4_drain", 200);
`ifdef SPONGENT_SCHEDULER_TIMEOUT_EN
        end_at = -1;
        req0_msg = 64'h7777_7777_7777_7777;
        req0_valid = 1'b1;
        job("t5_timeout", 1'b0, 64'h7777_7777_7777_7777, '0, 1'b1, 18);
        wait_drain("t5_drain", 100);
        end_at = TO - 1;
        req1_msg = 64'h8888_8888_8888_8888;
        req1_valid = 1'b1;
        job("t5_end_wins", 1'b1, 64'h8888_8888_8888_8888, model_hash(64'h8888_8888_8888_8888), 1'b0, 18);
        wait_drain("t5b_drain", 100);
        end_at = 49;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
